// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Keeps a shadow EX/MEM/WB scoreboard and drives operand-mux selects plus stall/flush controls.
module hazard_forward_unit #(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [REG_ADDR_W-1:0]  id_rs1,
   input  logic [REG_ADDR_W-1:0]  id_rs2,
   input  logic                   id_uses_rs1,
   input  logic                   id_uses_rs2,
   input  logic [REG_ADDR_W-1:0]  id_rd,
   input  logic                   id_reg_write,
   input  logic                   id_mem_read,
   input  logic                   redirect,
   input  logic                   stall_ext,
   output logic [1:0]             fwd_a_sel,
   output logic [1:0]             fwd_b_sel,
   output logic                   pc_write_en,
   output logic                   if_id_write_en,
   output logic                   if_id_flush,
   output logic                   id_ex_bubble,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } slot_t;

   slot_t ex_slot;
   slot_t mem_slot;
   slot_t wb_slot;

   logic load_use;
   logic count_stall;

   // A load in MEM has no ALU result worth forwarding yet, so only WB may supply load data.
   function automatic logic [1:0] pick_source(input slot_t ex, input slot_t mem, input slot_t wb,
                                               input logic [REG_ADDR_W-1:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (ex.valid) begin
         if (mem.valid && mem.reg_write && !mem.mem_read && (mem.rd != '0) && (mem.rd == src))
            sel = 2'b01;
         else if (wb.valid && wb.reg_write && (wb.rd != '0) && (wb.rd == src))
            sel = 2'b10;
      end
      return sel;
   endfunction

   always_comb begin
      load_use = ex_slot.valid && ex_slot.mem_read && (ex_slot.rd != '0) && id_valid &&
                 ((id_uses_rs1 && (id_rs1 == ex_slot.rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_slot.rd)));
   end

   // Control priority: reset, external freeze, redirect, load-use, normal run.
   always_comb begin
      fwd_a_sel      = pick_source(ex_slot, mem_slot, wb_slot, ex_slot.rs1);
      fwd_b_sel      = pick_source(ex_slot, mem_slot, wb_slot, ex_slot.rs2);
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      count_stall    = 1'b0;
      if (rst) begin
         fwd_a_sel = 2'b00;
         fwd_b_sel = 2'b00;
      end else if (stall_ext) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
      end else if (redirect) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_bubble   = 1'b1;
         count_stall    = 1'b1;
      end
   end

   // Scoreboard advances with the datapath registers; the counter saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_slot     <= '0;
         mem_slot    <= '0;
         wb_slot     <= '0;
         stall_count <= '0;
      end else if (!stall_ext) begin
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         if (id_ex_bubble || !id_valid) begin
            ex_slot <= '0;
         end else begin
            ex_slot.valid     <= 1'b1;
            ex_slot.rd        <= id_rd;
            ex_slot.reg_write <= id_reg_write;
            ex_slot.mem_read  <= id_mem_read;
            ex_slot.rs1       <= id_rs1;
            ex_slot.rs2       <= id_rs2;
         end
         if (count_stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule
